// File: rtl/spi_master.sv
// SPI mode-0 initiator that sends one 16-bit frame {addr[6:0], rw, data[7:0]} MSB first.
// The host side uses a start/busy/done handshake, and read data is returned on rdata at done.
module spi_master #(
    parameter int CLK_DIV = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       cs,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [4:0]       LAST_BIT  = 5'd16;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       bit_cnt;
    logic [14:0]      shreg;
    logic [7:0]       rsh;
    logic             rw_q;
    logic             half_end;
    logic [15:0]      frame;

    always_comb begin
        frame    = {addr, rw, rw ? 8'h00 : wdata};
        half_end = (cnt == HALF_LAST);
    end

    // NOTE: sequential state uses <= only, so every register sees its peers' pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            rsh     <= '0;
            rw_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
            cs      <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (start) begin
                        state <= SETUP;
                        busy  <= 1'b1;
                        cs    <= 1'b0;
                        rw_q  <= rw;
                        shreg <= frame[14:0];
                        mosi  <= frame[15];
                    end
                end
                SETUP: begin
                    if (half_end) begin
                        state <= SHIFT;
                        sclk  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        cnt <= '0;
                        if (sclk) begin
                            // The falling edge samples miso and presents the next bit.
                            sclk    <= 1'b0;
                            rsh     <= {rsh[6:0], miso};
                            shreg   <= {shreg[13:0], 1'b0};
                            mosi    <= shreg[14];
                            bit_cnt <= bit_cnt + 5'd1;
                        end else if (bit_cnt == LAST_BIT) begin
                            state <= HOLD;
                            mosi  <= 1'b0;
                        end else begin
                            sclk <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        state <= GAP;
                        cnt   <= '0;
                        cs    <= 1'b1;
                        done  <= 1'b1;
                        if (rw_q) begin
                            rdata <= rsh;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (half_end) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
